// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: FIFO-buffered command issuer for a single-port valid/ready memory.
// Define MEM_REQ_CTRL_TIMEOUT_EN to abort REQ after TIMEOUT cycles without ready and set err_o.
module mem_req_ctrl #(
  parameter int DW      = 16,
  parameter int AW      = 6,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic                       cmd_wr_rd_i,
  input  logic [AW-1:0]              cmd_addr_i,
  input  logic [DW-1:0]              cmd_wdata_i,
  output logic                       mem_valid_o,
  output logic                       mem_wr_rd_o,
  output logic [AW-1:0]              mem_addr_o,
  output logic [DW-1:0]              mem_wdata_o,
  input  logic                       mem_ready_i,
  input  logic [DW-1:0]              mem_rdata_i,
  output logic                       rsp_valid_o,
  output logic [DW-1:0]              rsp_rdata_o,
  output logic [AW-1:0]              rsp_addr_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       err_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + AW + DW;

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  logic [EW-1:0] fifo_q [DEPTH];
  state_t        state_q, state_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          mem_valid_q, mem_valid_d, mem_wr_rd_q, mem_wr_rd_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d, rsp_addr_q, rsp_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          push, pop, timed_out;

  assign cmd_ready_o = count_q != CW'(DEPTH);
  assign push        = cmd_valid_i && cmd_ready_o;
  assign pop         = state_q == IDLE && count_q != '0;

`ifdef MEM_REQ_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  always_comb begin
    timed_out = state_q == REQ && !mem_ready_i && tmo_q == TW'(TIMEOUT - 1);
    tmo_d     = state_q == REQ ? tmo_q + TW'(1) : '0;
    err_d     = err_q | timed_out;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign timed_out = 1'b0;
  assign err_o     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q + PW'(push);
    rptr_d      = rptr_q + PW'(pop);
    count_d     = count_q + CW'(push) - CW'(pop);
    mem_valid_d = mem_valid_q;
    mem_wr_rd_d = mem_wr_rd_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_addr_d  = rsp_addr_q;
    unique case (state_q)
      IDLE: if (pop) begin
        state_d     = REQ;
        mem_valid_d = 1'b1;
        {mem_wr_rd_d, mem_addr_d, mem_wdata_d} = fifo_q[rptr_q];
      end
      REQ: if (mem_ready_i || timed_out) begin
        state_d     = GAP;
        mem_valid_d = 1'b0;
        mem_wr_rd_d = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        // an aborted read still answers, with zero data
        if (!mem_wr_rd_q) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = mem_ready_i ? mem_rdata_i : '0;
          rsp_addr_d  = mem_addr_q;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= {cmd_wr_rd_i, cmd_addr_i, cmd_wdata_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_wr_rd_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      mem_valid_q <= mem_valid_d;
      mem_wr_rd_q <= mem_wr_rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_addr_q  <= rsp_addr_d;
    end
  end

  assign mem_valid_o = mem_valid_q;
  assign mem_wr_rd_o = mem_wr_rd_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_addr_o  = rsp_addr_q;
  assign count_o     = count_q;
  assign busy_o      = state_q != IDLE || count_q != '0;
endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: directed scenarios against a small behavioural memory model.
module tb_mem_req_ctrl;
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_wr_rd_i = 1'b0;
  logic [5:0]  cmd_addr_i = '0;
  logic [15:0] cmd_wdata_i = '0;
  logic        mem_valid_o, mem_wr_rd_o, mem_ready_i = 1'b0;
  logic [5:0]  mem_addr_o, rsp_addr_o;
  logic [15:0] mem_wdata_o, mem_rdata_i, rsp_rdata_o;
  logic        rsp_valid_o, busy_o, err_o;
  logic [2:0]  count_o;
  logic        auto_rdy = 1'b0;
  logic [15:0] mem_arr [0:63];
  logic [5:0]  log_a [0:63];
  int          log_n = 0;
  int          checks = 0, failures = 0;

  mem_req_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_rd_i(cmd_wr_rd_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .mem_valid_o(mem_valid_o), .mem_wr_rd_o(mem_wr_rd_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_addr_o(rsp_addr_o),
    .busy_o(busy_o), .count_o(count_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // memory answers ready one cycle after it sees valid, when enabled
  assign mem_rdata_i = mem_arr[mem_addr_o];
  always @(posedge clk) begin
    mem_ready_i <= auto_rdy && mem_valid_o && !mem_ready_i;
    if (rst_ni && mem_valid_o && mem_ready_i) begin
      if (mem_wr_rd_o) mem_arr[mem_addr_o] <= mem_wdata_o;
      log_a[log_n] <= mem_addr_o;
      log_n <= log_n + 1;
    end
  end

  task automatic push(input logic w, input logic [5:0] a, input logic [15:0] d);
    int n = 0;
    cmd_valid_i = 1'b1; cmd_wr_rd_i = w; cmd_addr_i = a; cmd_wdata_i = d;
    while (!cmd_ready_o && n < 50) begin @(negedge clk); n++; end
    if (n == 50) begin checks++; failures++; $display("FAIL push_accept addr=%0d not accepted in 50 cycles", a); end
    @(posedge clk); @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    auto_rdy = 1'b0;
    cmd_valid_i = 1'b0;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    auto_rdy = 1'b0;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (cmd_ready_o !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready_o); end
    checks++; if (mem_valid_o !== 1'b0) begin failures++; $display("FAIL rst_mem_valid got=%b exp=0", mem_valid_o); end
    checks++; if ({mem_wr_rd_o, mem_addr_o, mem_wdata_o} !== 23'd0) begin failures++; $display("FAIL rst_mem_bus got=%h exp=0", {mem_wr_rd_o, mem_addr_o, mem_wdata_o}); end
    checks++; if ({rsp_valid_o, rsp_rdata_o, rsp_addr_o} !== 23'd0) begin failures++; $display("FAIL rst_rsp got=%h exp=0", {rsp_valid_o, rsp_rdata_o, rsp_addr_o}); end
    checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count_o); end
    checks++; if ({busy_o, err_o} !== 2'b00) begin failures++; $display("FAIL rst_busy_err got=%b exp=00", {busy_o, err_o}); end
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round_trip();
    int pulses = 0;
    logic [15:0] rd = '0;
    logic [5:0]  ad = '0;
    auto_rdy = 1'b1;
    push(1'b1, 6'd50, 16'hA5C3);
    checks++; if (count_o !== 3'd1 || mem_valid_o !== 1'b0) begin failures++; $display("FAIL rt_after_push count=%0d valid=%b exp=1,0", count_o, mem_valid_o); end
    @(negedge clk);
    checks++; if ({mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b1, 6'd50, 16'hA5C3}) begin failures++; $display("FAIL rt_issue got=%h exp=%h", {mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o}, {1'b1, 1'b1, 6'd50, 16'hA5C3}); end
    push(1'b0, 6'd50, 16'h0);
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid_o) begin pulses++; rd = rsp_rdata_o; ad = rsp_addr_o; end
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL rt_pulses got=%0d exp=1", pulses); end
    checks++; if (rd !== 16'hA5C3) begin failures++; $display("FAIL rt_rdata got=%h exp=a5c3", rd); end
    checks++; if (ad !== 6'd50) begin failures++; $display("FAIL rt_raddr got=%0d exp=50", ad); end
    checks++; if (rsp_rdata_o !== 16'hA5C3 || busy_o !== 1'b0) begin failures++; $display("FAIL rt_hold rdata=%h busy=%b exp=a5c3,0", rsp_rdata_o, busy_o); end
  endtask

  task automatic test_fifo_full();
    int base = log_n;
    int n = 0;
    logic stuck = 1'b0;
    auto_rdy = 1'b0;
    for (int i = 1; i <= 5; i++) push(1'b1, 6'(i), 16'h100 + 16'(i));
    checks++; if (count_o !== 3'd4 || cmd_ready_o !== 1'b0) begin failures++; $display("FAIL full_state count=%0d ready=%b exp=4,0", count_o, cmd_ready_o); end
    checks++; if (mem_valid_o !== 1'b1 || mem_addr_o !== 6'd1) begin failures++; $display("FAIL full_head valid=%b addr=%0d exp=1,1", mem_valid_o, mem_addr_o); end
    cmd_valid_i = 1'b1; cmd_wr_rd_i = 1'b1; cmd_addr_i = 6'd6; cmd_wdata_i = 16'h106;
    repeat (3) begin @(negedge clk); if (cmd_ready_o) stuck = 1'b1; end
    checks++; if (stuck !== 1'b0) begin failures++; $display("FAIL full_blocked ready rose while stalled"); end
    auto_rdy = 1'b1;
    while (!cmd_ready_o && n < 20) begin @(negedge clk); n++; end
    checks++; if (n == 20 || mem_addr_o !== 6'd2) begin failures++; $display("FAIL full_accept wait=%0d addr=%0d exp=<20,2", n, mem_addr_o); end
    @(posedge clk); @(negedge clk);
    cmd_valid_i = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (log_n - base != 6) begin failures++; $display("FAIL full_drain got=%0d exp=6", log_n - base); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (log_a[base + i] !== 6'(i + 1)) begin failures++; $display("FAIL full_order idx=%0d got=%0d exp=%0d", i, log_a[base + i], i + 1); end
    end
  endtask

  task automatic test_delayed_ready();
    int n = 0;
    int low = 0;
    logic stable = 1'b1;
    auto_rdy = 1'b0;
    push(1'b1, 6'd9, 16'h1234);
    push(1'b1, 6'd10, 16'h5678);
    checks++; if (mem_valid_o !== 1'b1) begin failures++; $display("FAIL dly_valid got=%b exp=1", mem_valid_o); end
    repeat (5) begin
      @(negedge clk);
      if (!mem_valid_o || !mem_wr_rd_o || mem_addr_o !== 6'd9 || mem_wdata_o !== 16'h1234) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin failures++; $display("FAIL dly_stable outputs changed while valid"); end
    auto_rdy = 1'b1;
    while (mem_valid_o && n < 10) begin @(negedge clk); n++; end
    checks++; if ({mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o} !== 24'd0) begin failures++; $display("FAIL dly_gap_bus got=%h exp=0", {mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o}); end
    while (!mem_valid_o && low < 10) begin low++; @(negedge clk); end
    checks++; if (low != 2) begin failures++; $display("FAIL dly_gap_len got=%0d exp=2", low); end
    checks++; if (mem_addr_o !== 6'd10 || mem_wdata_o !== 16'h5678) begin failures++; $display("FAIL dly_next addr=%0d data=%h exp=10,5678", mem_addr_o, mem_wdata_o); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_push_pop_same_edge();
    int base = log_n;
    int n = 0;
    auto_rdy = 1'b0;
    push(1'b1, 6'd20, 16'h20);
    push(1'b1, 6'd21, 16'h21);
    push(1'b1, 6'd22, 16'h22);
    checks++; if (count_o !== 3'd2) begin failures++; $display("FAIL pp_pre count=%0d exp=2", count_o); end
    auto_rdy = 1'b1;
    while (mem_valid_o && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_wr_rd_i = 1'b1; cmd_addr_i = 6'd23; cmd_wdata_i = 16'h23;
    @(posedge clk); @(negedge clk);
    cmd_valid_i = 1'b0;
    checks++; if (count_o !== 3'd2 || mem_addr_o !== 6'd21) begin failures++; $display("FAIL pp_same count=%0d addr=%0d exp=2,21", count_o, mem_addr_o); end
    repeat (30) @(negedge clk);
    checks++; if (log_n - base != 4) begin failures++; $display("FAIL pp_drain got=%0d exp=4", log_n - base); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (log_a[base + i] !== 6'(20 + i)) begin failures++; $display("FAIL pp_order idx=%0d got=%0d exp=%0d", i, log_a[base + i], 20 + i); end
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int req = 0;
    logic held = 1'b1;
    auto_rdy = 1'b0;
    push(1'b0, 6'd7, 16'h0);
`ifdef MEM_REQ_CTRL_TIMEOUT_EN
    while (!mem_valid_o && n < 10) begin @(negedge clk); n++; end
    while (mem_valid_o && req < 100) begin req++; @(negedge clk); end
    checks++; if (req != 15) begin failures++; $display("FAIL tmo_req_cycles got=%0d exp=15", req); end
    checks++; if ({rsp_valid_o, rsp_rdata_o, rsp_addr_o} !== {1'b1, 16'h0, 6'd7}) begin failures++; $display("FAIL tmo_rsp got=%h exp=%h", {rsp_valid_o, rsp_rdata_o, rsp_addr_o}, {1'b1, 16'h0, 6'd7}); end
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL tmo_err got=%b exp=1", err_o); end
    repeat (10) begin @(negedge clk); if (err_o !== 1'b1) held = 1'b0; end
    checks++; if (held !== 1'b1) begin failures++; $display("FAIL tmo_sticky err dropped before reset"); end
    do_reset();
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL tmo_err_rst got=%b exp=0", err_o); end
`else
    repeat (40) begin @(negedge clk); if (err_o !== 1'b0 || mem_valid_o !== 1'b1) held = 1'b0; end
    checks++; if (held !== 1'b1) begin failures++; $display("FAIL notmo_wait err=%b valid=%b exp=0,1", err_o, mem_valid_o); end
    do_reset();
`endif
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    int seen = 0;
    auto_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push(1'b0, 6'(30 + i), 16'h0);
    checks++; if (count_o !== 3'd3 || mem_valid_o !== 1'b1) begin failures++; $display("FAIL rm_pre count=%0d valid=%b exp=3,1", count_o, mem_valid_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (mem_valid_o !== 1'b0 || count_o !== 3'd0) begin failures++; $display("FAIL rm_async valid=%b count=%0d exp=0,0", mem_valid_o, count_o); end
    checks++; if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin failures++; $display("FAIL rm_flags ready=%b busy=%b exp=1,0", cmd_ready_o, busy_o); end
    @(negedge clk);
    rst_ni = 1'b1;
    auto_rdy = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid_o) pulses++;
      if (mem_valid_o) seen++;
    end
    checks++; if (pulses != 0 || seen != 0) begin failures++; $display("FAIL rm_after rsp=%0d valid=%0d exp=0,0", pulses, seen); end
  endtask

  initial begin
    test_reset();
    test_round_trip();
    test_fifo_full();
    test_delayed_ready();
    test_push_pop_same_edge();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
